onchip_ram_banked: RTL and testbench
====================================

ONCHIP_RAM_BANKED -- requirements
Module: onchip_ram_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width in bits (multiple of 8, power of two).
REQ-002 SHALL have parameter NUM_BANKS, default 32, meaning SRAM bank count (power of two, >=1).
REQ-003 SHALL have parameter BANK_WORDS, default 1024, meaning words per bank (power of two).
REQ-004 SHALL have parameter ADDR_W, default 32, meaning request byte-address width.
REQ-005 SHALL have parameter INIT_ZERO, default 1, meaning zero-fill all banks after reset when 1.
REQ-006 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port req_valid_i  input  1  request valid.
REQ-009 SHALL have port req_ready_o  output  1  request accepted when valid and ready both high.
REQ-010 SHALL have port req_addr_i  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wstrb_i  input  DATA_W/8  byte write enables; all-zero means read.
REQ-012 SHALL have port req_wdata_i  input  DATA_W  write data.
REQ-013 SHALL have port rsp_valid_o  output  1  response valid.
REQ-014 SHALL have port rsp_ready_i  input  1  response consumed when valid and ready both high.
REQ-015 SHALL have port rsp_rdata_o  output  DATA_W  read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err_o  output  1  address out of range.
REQ-017 SHALL have port init_done_o  output  1  high once zero-fill complete (or immediately if INIT_ZERO=0).

Function
REQ-018 SHALL decode: word offset = low log2(DATA_W/8) bits ignored; next log2(BANK_WORDS) bits = bank row; next log2(NUM_BANKS) bits = bank select.
REQ-019 SHALL flag out-of-range when req_addr_i >= NUM_BANKS*BANK_WORDS*DATA_W/8; such requests SHALL touch no bank and respond rsp_err_o=1, rsp_rdata_o=0.
REQ-020 SHALL assert chip-select only on the one addressed bank, only in the accept cycle; all others idle.
REQ-021 SHALL write only bytes whose wstrb bit is set; unselected bytes keep old value.
REQ-022 SHALL use banks with 1-cycle read latency; rdata captured from the bank selected in the previous cycle (registered bank index mux).
REQ-023 SHALL produce exactly one response per accepted request, in acceptance order, writes included (rdata 0, err 0).
REQ-024 SHALL deliver response earliest one cycle after acceptance (rsp_valid_o high in cycle N+1 for accept in N).
REQ-025 SHALL hold a 2-entry response buffer; req_ready_o = (buffered + in-flight) < 2, computed from registered state only (no combinational path from req_valid_i).
REQ-026 SHALL sustain one request per cycle while rsp_ready_i stays high.
REQ-027 SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-028 SHALL return newly written data for a read accepted any cycle after the write's acceptance (back-to-back RAW correct).
REQ-029 SHALL implement FSM INIT -> RUN: INIT entered on reset when INIT_ZERO=1, RUN directly when INIT_ZERO=0.
REQ-030 SHALL in INIT write zero to row k of every bank in parallel, k counting 0..BANK_WORDS-1, one row per cycle, req_ready_o=0.
REQ-031 SHALL go INIT->RUN after row BANK_WORDS-1 write, setting init_done_o=1 in the first RUN cycle (BANK_WORDS cycles after reset release).
REQ-032 SHALL never leave RUN except by reset.

Reset
REQ-033 SHALL on rst_n_i=0 at a clock edge clear buffer, in-flight flag, row counter; rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=0, init_done_o=0.
REQ-034 SHALL drop any in-flight or buffered response when reset occurs mid-operation; memory contents after reset are undefined unless INIT re-runs.
REQ-035 SHALL assert req_ready_o the first cycle after reset release when INIT_ZERO=0.

Verification
REQ-036 SHALL cover init: INIT_ZERO=1, BANK_WORDS=16, release reset -> init_done_o rises after 16 cycles; read any in-range addr -> rdata 0.
REQ-037 SHALL cover byte write: write 0xAABBCCDD strb 4'hF to 0x0, then 0x11 strb 4'b0001 -> read 0x0 returns 0xAABBCC11.
REQ-038 SHALL cover bank boundary: write 0x1 to last word of bank 0 and 0x2 to first word of bank 1 (addr 0xFFC/0x1000, defaults) -> reads return 0x1, 0x2.
REQ-039 SHALL cover backpressure: stream 8 reads with rsp_ready_i=0 -> exactly 2 accepted, req_ready_o low; raise rsp_ready_i -> remaining 6 complete in order, no loss/duplication.
REQ-040 SHALL cover error: read at addr 0x20000 (defaults) -> rsp_err_o=1, rdata 0, no bank cs.
REQ-041 SHALL cover reset mid-stream: reset asserted with 2 responses pending -> rsp_valid_o=0 next cycle, no stale response after release.

Source files
------------

// File: rtl/onchip_ram_banked.sv
// onchip_ram_banked: banked single-port SRAM behind valid/ready request and response channels
// Ports: clk_i, rst_n_i (sync, active-low); req_valid_i/req_ready_o, req_addr_i (byte address),
// req_wstrb_i (all-zero = read), req_wdata_i; rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o
// (address out of range); init_done_o (zero-fill finished, or straight after reset without it).
module onchip_ram_banked #(
    parameter int DATA_W     = 32,
    parameter int NUM_BANKS  = 32,
    parameter int BANK_WORDS = 1024,
    parameter int ADDR_W     = 32,
    parameter int INIT_ZERO  = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                init_done_o
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int ROW_W  = $clog2(BANK_WORDS);
    localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int MEM_AW = OFF_W + ROW_W + $clog2(NUM_BANKS);

    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t state;
    logic [ROW_W-1:0] init_row;

    logic [ROW_W-1:0]  req_row, bank_row;
    logic [BANK_W-1:0] req_bank, f_bank;
    logic              req_oor, accept, init_busy;
    logic [NB-1:0]     bank_wstrb;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    logic              f_valid, f_read, f_err;
    logic [DATA_W-1:0] f_data;
    logic [1:0]        q_cnt;
    logic              q_wp, q_rp;
    logic [DATA_W-1:0] q_data [2];
    logic [1:0]        q_err;
    logic              pop, q_pop, push;

    // any address bit above the mapped range marks the request out of range
    assign req_oor  = (req_addr_i >> MEM_AW) != '0;
    assign req_row  = ROW_W'(req_addr_i >> OFF_W);
    assign req_bank = BANK_W'((req_addr_i >> (OFF_W + ROW_W)) & ADDR_W'(NUM_BANKS - 1));

    // occupancy counts only registered state, so ready never depends on req_valid_i
    assign req_ready_o = rst_n_i && state == S_RUN && (q_cnt + {1'b0, f_valid}) < 2'd2;
    assign accept      = req_valid_i && req_ready_o;
    assign init_done_o = rst_n_i && state == S_RUN;

    // during zero-fill every bank writes the same row in parallel
    assign init_busy  = state == S_INIT;
    assign bank_row   = init_busy ? init_row : req_row;
    assign bank_wstrb = init_busy ? '1 : req_wstrb_i;
    assign bank_wdata = init_busy ? '0 : req_wdata_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [BANK_WORDS];
        logic [DATA_W-1:0] rdata;
        logic              cs;
        assign cs = init_busy || (accept && !req_oor && req_bank == BANK_W'(b));
        always_ff @(posedge clk_i) begin
            if (cs) begin
                for (int i = 0; i < NB; i++)
                    if (bank_wstrb[i]) mem[bank_row][i*8 +: 8] <= bank_wdata[i*8 +: 8];
                rdata <= mem[bank_row];
            end
        end
        assign bank_rdata[b] = rdata;
    end

    // the in-flight stage is the newest response; buffered entries are older and go first
    assign f_data      = f_read ? bank_rdata[f_bank] : '0;
    assign rsp_valid_o = q_cnt != 2'd0 || f_valid;
    assign rsp_rdata_o = q_cnt != 2'd0 ? q_data[q_rp] : f_data;
    assign rsp_err_o   = q_cnt != 2'd0 ? q_err[q_rp] : f_err;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign q_pop       = pop && q_cnt != 2'd0;
    assign push        = f_valid && !(pop && q_cnt == 2'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            f_valid <= 1'b0;
            f_read  <= 1'b0;
            f_err   <= 1'b0;
            q_cnt   <= 2'd0;
            q_wp    <= 1'b0;
            q_rp    <= 1'b0;
        end else begin
            f_valid <= accept;
            f_read  <= accept && !req_oor && req_wstrb_i == '0;
            f_err   <= accept && req_oor;
            f_bank  <= req_bank;
            if (push) begin
                q_data[q_wp] <= f_data;
                q_err[q_wp]  <= f_err;
                q_wp         <= !q_wp;
            end
            if (q_pop) q_rp <= !q_rp;
            q_cnt <= q_cnt + {1'b0, push} - {1'b0, q_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= INIT_ZERO != 0 ? S_INIT : S_RUN;
            init_row <= '0;
        end else if (state == S_INIT) begin
            init_row <= init_row + ROW_W'(1);
            if (init_row == ROW_W'(BANK_WORDS - 1)) state <= S_RUN;
        end
    end
endmodule

// File: tb/tb_onchip_ram_banked.sv
// tb_onchip_ram_banked: directed scenario tests for onchip_ram_banked
module tb_onchip_ram_banked;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, init_done;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;
    logic        s_ready, s_valid, s_err, s_done;
    logic [31:0] s_rdata;
    logic        z_ready, z_valid, z_err, z_done;
    logic [31:0] z_rdata;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [32:0] rq [$];

    always #5 clk = ~clk;

    onchip_ram_banked dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .init_done_o(init_done)
    );

    onchip_ram_banked #(.NUM_BANKS(4), .BANK_WORDS(16)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(1'b0), .req_ready_o(s_ready), .req_addr_i(32'h0),
        .req_wstrb_i(4'h0), .req_wdata_i(32'h0),
        .rsp_valid_o(s_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(s_rdata),
        .rsp_err_o(s_err), .init_done_o(s_done)
    );

    onchip_ram_banked #(.NUM_BANKS(2), .BANK_WORDS(16), .INIT_ZERO(0)) dut_z (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(1'b0), .req_ready_o(z_ready), .req_addr_i(32'h0),
        .req_wstrb_i(4'h0), .req_wdata_i(32'h0),
        .rsp_valid_o(z_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(z_rdata),
        .rsp_err_o(z_err), .init_done_o(z_done)
    );

    // record the response consumed at the coming edge, then advance one cycle
    task automatic step();
        if (rst_n && rsp_valid && rsp_ready) rq.push_back({rsp_err, rsp_rdata});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wstrb = s;
        req_wdata = d;
        while (!req_ready && n < 64) begin
            step();
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout addr=%h ready=%b required=1", a, req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rq.size() < n && k < 64) begin
            step();
            k++;
        end
        if (rq.size() < n) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout got=%0d required=%0d", rq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({rsp_valid, req_ready, init_done, rsp_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000", {rsp_valid, req_ready, init_done, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h required=0", rsp_rdata);
        end
        checks++;
        if ({z_ready, z_done, s_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_other got=%b required=000", {z_ready, z_done, s_done});
        end
    endtask

    task automatic test_init();
        int m_n, s_n;
        m_n = 0;
        s_n = 0;
        rst_n = 1'b1;
        for (int n = 1; n <= 1100 && m_n == 0; n++) begin
            step();
            if (n == 1) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL init_ready got=%b required=0", req_ready);
                end
                checks++;
                if ({z_ready, z_done} !== 2'b11) begin
                    failures++;
                    $display("FAIL noinit_ready got=%b required=11", {z_ready, z_done});
                end
            end
            if (s_done === 1'b1 && s_n == 0) s_n = n;
            if (init_done === 1'b1 && m_n == 0) m_n = n;
        end
        checks++;
        if (s_n != 16) begin
            failures++;
            $display("FAIL init_small_cycles got=%0d required=16", s_n);
        end
        checks++;
        if (m_n != 1024) begin
            failures++;
            $display("FAIL init_default_cycles got=%0d required=1024", m_n);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_ready got=%b required=1", req_ready);
        end
        checks++;
        if ({s_valid, s_err, z_valid, z_err} !== 4'b0 || s_rdata !== 32'h0 || z_rdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_rsp got=%b %h %h required=0000 0 0", {s_valid, s_err, z_valid, z_err}, s_rdata, z_rdata);
        end
    endtask

    task automatic test_byte_write();
        logic [32:0] exp [6] = '{33'h0, 33'h0, 33'h0AABBCC11, 33'h0, 33'h0, 33'h055EEFF11};
        logic [32:0] r;
        rq.delete();
        issue(32'h0, 4'hF, 32'hAABBCCDD);
        issue(32'h0, 4'h1, 32'h00000011);
        issue(32'h0, 4'h0, 32'h0);
        issue(32'h0, 4'h8, 32'h55000000);
        issue(32'h0, 4'h6, 32'h00EEFF00);
        issue(32'h2, 4'h0, 32'h0);
        wait_rsp(6);
        for (int i = 0; i < 6; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== exp[i]) begin
                failures++;
                $display("FAIL byte_write[%0d] got=%h required=%h", i, r, exp[i]);
            end
        end
    endtask

    task automatic test_bank_boundary();
        logic [32:0] exp [7] = '{33'h0, 33'h0, 33'h0, 33'h000000001, 33'h000000002, 33'h000000003, 33'h0};
        logic [32:0] r;
        rq.delete();
        issue(32'h00FFC, 4'hF, 32'h1);
        issue(32'h01000, 4'hF, 32'h2);
        issue(32'h1FFFC, 4'hF, 32'h3);
        issue(32'h00FFC, 4'h0, 32'h0);
        issue(32'h01000, 4'h0, 32'h0);
        issue(32'h1FFFF, 4'h0, 32'h0);
        issue(32'h00FF8, 4'h0, 32'h0);
        wait_rsp(7);
        for (int i = 0; i < 7; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== exp[i]) begin
                failures++;
                $display("FAIL boundary[%0d] got=%h required=%h", i, r, exp[i]);
            end
        end
    endtask

    task automatic test_error();
        logic [32:0] exp [5] = '{33'h100000000, 33'h100000000, 33'h100000000, 33'h055EEFF11, 33'h000000003};
        logic [32:0] r;
        rq.delete();
        issue(32'h00020000, 4'h0, 32'h0);
        issue(32'h00020000, 4'hF, 32'hDEADBEEF);
        issue(32'hFFFFFFFC, 4'hF, 32'h12345678);
        issue(32'h00000000, 4'h0, 32'h0);
        issue(32'h0001FFFC, 4'h0, 32'h0);
        wait_rsp(5);
        for (int i = 0; i < 5; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== exp[i]) begin
                failures++;
                $display("FAIL error[%0d] got=%h required=%h", i, r, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp [5] = '{33'h0, 33'h012345678, 33'h0, 33'h0CAFE5678, 33'h0};
        logic [32:0] r;
        int c0;
        rq.delete();
        c0 = cyc;
        issue(32'h80, 4'hF, 32'h12345678);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_latency got=%b required=1", rsp_valid);
        end
        issue(32'h80, 4'h0, 32'h0);
        issue(32'h80, 4'hC, 32'hCAFE0000);
        issue(32'h80, 4'h0, 32'h0);
        issue(32'h84, 4'h0, 32'h0);
        checks++;
        if (cyc - c0 != 5) begin
            failures++;
            $display("FAIL throughput got=%0d required=5", cyc - c0);
        end
        wait_rsp(5);
        for (int i = 0; i < 5; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== exp[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h required=%h", i, r, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        acc;
        int          idx;
        logic [32:0] r;
        for (int i = 0; i < 8; i++) issue(32'(i) * 32'h1000 + 32'h10, 4'hF, 32'hB0B00000 + 32'(i));
        wait_rsp(8);
        rq.delete();
        rsp_ready = 1'b0;
        idx = 0;
        req_valid = 1'b1;
        req_wstrb = 4'h0;
        req_wdata = 32'h0;
        req_addr  = 32'h10;
        for (int c = 0; c < 10; c++) begin
            acc = req_ready;
            step();
            if (acc) begin
                idx++;
                req_addr = 32'(idx) * 32'h1000 + 32'h10;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB0B00000 || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%b %h %b required=1 b0b00000 0", c, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        checks++;
        if (idx != 2) begin
            failures++;
            $display("FAIL stall_accepts got=%0d required=2", idx);
        end
        checks++;
        if (req_ready !== 1'b0 || rq.size() != 0) begin
            failures++;
            $display("FAIL stall_state got=%b/%0d required=0/0", req_ready, rq.size());
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 64 && idx < 8; c++) begin
            acc = req_ready;
            step();
            if (acc) begin
                idx++;
                req_addr = 32'(idx) * 32'h1000 + 32'h10;
            end
        end
        req_valid = 1'b0;
        wait_rsp(8);
        for (int i = 0; i < 8; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== {1'b0, 32'hB0B00000 + 32'(i)}) begin
                failures++;
                $display("FAIL drain[%0d] got=%h required=%h", i, r, {1'b0, 32'hB0B00000 + 32'(i)});
            end
        end
        repeat (4) step();
        checks++;
        if (rq.size() != 0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_extra got=%0d/%b required=0/0", rq.size(), rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] r;
        int          k;
        rq.delete();
        rsp_ready = 1'b0;
        issue(32'h0, 4'h0, 32'h0);
        issue(32'h1000, 4'h0, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_pending got=%b%b required=10", rsp_valid, req_ready);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({rsp_valid, req_ready, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got=%b %h required=000 0", {rsp_valid, req_ready, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        k = 0;
        while (init_done !== 1'b1 && k < 1100) begin
            step();
            k++;
        end
        checks++;
        if (init_done !== 1'b1 || rq.size() != 0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release got=%b/%0d/%b required=1/0/0", init_done, rq.size(), rsp_valid);
        end
        issue(32'h0, 4'h0, 32'h0);
        issue(32'h1000, 4'h0, 32'h0);
        wait_rsp(2);
        for (int i = 0; i < 2; i++) begin
            r = rq.pop_front();
            checks++;
            if (r !== 33'h0) begin
                failures++;
                $display("FAIL mid_rezero[%0d] got=%h required=0", i, r);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wstrb = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_init();
        test_byte_write();
        test_bank_boundary();
        test_error();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
